// File: rtl/metro_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : metro_pkg
//  Description : Shared definitions for the metro card reader and the
//                downstream fare FSM: reader state encoding, field widths
//                and frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
package metro_pkg;

    // Default field widths shared with the fare FSM
    localparam int CODE_BITS_DFLT  = 6;
    localparam int MONEY_BITS_DFLT = 14;
    localparam int CSUM_BITS       = 4;

    // Start bit + code + balance + checksum + stop bit
    function automatic int frame_bits_f(input int code_bits, input int money_bits);
        return code_bits + money_bits + CSUM_BITS + 2;
    endfunction

    localparam int FRAME_BITS = frame_bits_f(CODE_BITS_DFLT, MONEY_BITS_DFLT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DEBOUNCE   = 3'd1,
        S_WAIT_START = 3'd2,
        S_DATA       = 3'd3,
        S_CHECK      = 3'd4,
        S_HOLD       = 3'd5,
        S_ERROR      = 3'd6
    } reader_state_t;

endpackage : metro_pkg
`default_nettype wire

// File: rtl/metro_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : metro_debouncer
//  Description : Two-flop synchroniser for the raw card-presence contact
//                plus a saturating counter of consecutive ena ticks seen
//                with the card present.
//  Revision    : 1.0 - initial release
// ============================================================================
module metro_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,          // asynchronous, active-low
    input  logic i_ena,
    input  logic i_card_present, // raw, asynchronous contact
    input  logic i_clear,        // hold the count at zero
    output logic o_present,      // synchronised presence
    output logic o_stable        // count has reached DEBOUNCE
);

    localparam int c_CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_count;

    // Synchroniser; idles at "no card"
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_card_present};
        end
    end

    assign o_present = r_sync[1];

    // Count ena ticks while present; any absence restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear || !o_present) begin
            r_count <= '0;
        end else if (i_ena && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_stable = (r_count == c_CNT_MAX);

endmodule : metro_debouncer
`default_nettype wire

// File: rtl/metro_card_reader.sv
`default_nettype none
// ============================================================================
//  Module      : metro_card_reader
//  Description : Debounces card insertion, receives an LSB-first serial
//                frame {stop, checksum, balance, code, start}, verifies the
//                nibble-XOR checksum and stop bit, and holds the verified
//                code and balance while the card stays present.
//  Revision    : 1.0 - initial release
// ============================================================================
module metro_card_reader
    import metro_pkg::*;
#(
    parameter int CODE_BITS  = CODE_BITS_DFLT,
    parameter int MONEY_BITS = MONEY_BITS_DFLT,
    parameter int DEBOUNCE   = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,          // asynchronous, active-low
    input  logic                  ena,
    input  logic                  card_present,
    input  logic                  sdata,
    output logic                  isCardAttached,
    output logic [CODE_BITS-1:0]  code,
    output logic [MONEY_BITS-1:0] currentBalance,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int c_DATA_BITS  = CODE_BITS + MONEY_BITS;
    localparam int c_PAD_BITS   = ((c_DATA_BITS + 3) / 4) * 4;
    localparam int c_NIBBLES    = c_PAD_BITS / 4;
    localparam int c_FRAME_BITS = frame_bits_f(CODE_BITS, MONEY_BITS);
    localparam int c_SHIFT_BITS = c_FRAME_BITS - 1;             // everything after start
    localparam int c_IDX_W      = $clog2(c_FRAME_BITS);
    localparam int c_TO_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_SHIFT_BITS - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(TIMEOUT);

    reader_state_t             r_state, w_next;
    logic [1:0]                r_sdata_sync;
    logic                      w_sdata;
    logic                      w_present;
    logic                      w_stable;
    logic [c_SHIFT_BITS-1:0]   r_shift;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_TO_W-1:0]         r_to_cnt;
    logic [CODE_BITS-1:0]      r_code;
    logic [MONEY_BITS-1:0]     r_balance;
    logic                      r_valid;
    logic                      r_err;
    logic                      w_load;
    logic                      w_fail;
    logic [c_PAD_BITS-1:0]     w_padded;
    logic [CSUM_BITS-1:0]      w_csum;
    logic [CSUM_BITS-1:0]      w_rx_csum;
    logic                      w_rx_stop;

    metro_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clk            (clk),
        .reset          (reset),
        .i_ena          (ena),
        .i_card_present (card_present),
        .i_clear        (r_state != S_DEBOUNCE),
        .o_present      (w_present),
        .o_stable       (w_stable)
    );

    // Serial line synchroniser; idles high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sdata_sync <= 2'b11;
        end else begin
            r_sdata_sync <= {r_sdata_sync[0], sdata};
        end
    end

    assign w_sdata = r_sdata_sync[1];

    // Received fields: code sits in the low bits, stop bit in the MSB
    assign w_rx_csum = r_shift[c_DATA_BITS +: CSUM_BITS];
    assign w_rx_stop = r_shift[c_SHIFT_BITS-1];

    // XOR of all nibbles of {balance, code}, zero-padded at the top
    always_comb begin
        w_padded                  = '0;
        w_padded[c_DATA_BITS-1:0] = r_shift[c_DATA_BITS-1:0];
        w_csum                    = '0;
        for (int i = 0; i < c_NIBBLES; i++) begin
            w_csum = w_csum ^ w_padded[i*4 +: 4];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; card removal overrides everything and never flags an error
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_fail = 1'b0;
        if (!w_present) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       w_next = S_DEBOUNCE;
                S_DEBOUNCE:   if (w_stable) w_next = S_WAIT_START;
                S_WAIT_START: begin
                    if (ena) begin
                        if (!w_sdata) begin
                            w_next = S_DATA;
                        end else if (r_to_cnt == c_TO_LAST) begin
                            w_next = S_ERROR;
                            w_fail = 1'b1;
                        end
                    end
                end
                S_DATA:       if (ena && (r_idx == c_IDX_LAST)) w_next = S_CHECK;
                S_CHECK: begin
                    if ((w_csum == w_rx_csum) && w_rx_stop) begin
                        w_next = S_HOLD;
                        w_load = 1'b1;
                    end else begin
                        w_next = S_ERROR;
                        w_fail = 1'b1;
                    end
                end
                S_HOLD:       w_next = S_HOLD;
                S_ERROR:      w_next = S_ERROR;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    // Start-bit timeout and bit-index counters, both saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
            r_idx    <= '0;
        end else begin
            if (r_state != S_WAIT_START) begin
                r_to_cnt <= '0;
            end else if (ena && w_sdata && (r_to_cnt != c_TO_MAX)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state != S_DATA) begin
                r_idx <= '0;
            end else if (ena && (r_idx != c_IDX_LAST)) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Frame shift register, filled from the top so the first bit lands in bit 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (r_state == S_IDLE) begin
            r_shift <= '0;
        end else if ((r_state == S_DATA) && ena) begin
            r_shift <= {w_sdata, r_shift[c_SHIFT_BITS-1:1]};
        end
    end

    // Result registers and one-clk status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_code    <= '0;
            r_balance <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_load;
            r_err   <= w_fail;
            if (w_next == S_IDLE) begin
                r_code    <= '0;
                r_balance <= '0;
            end else if (w_load) begin
                r_code    <= r_shift[CODE_BITS-1:0];
                r_balance <= r_shift[CODE_BITS +: MONEY_BITS];
            end
        end
    end

    assign isCardAttached = (r_state == S_HOLD);
    assign code           = r_code;
    assign currentBalance = r_balance;
    assign frame_valid    = r_valid;
    assign frame_err      = r_err;

endmodule : metro_card_reader
`default_nettype wire

// File: tb/tb_metro_card_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_metro_card_reader
//  Description : Self-checking bench for metro_card_reader: directed cases
//                plus randomized frames against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_metro_card_reader;

    localparam int CB  = 6;
    localparam int MB  = 14;
    localparam int DEB = 4;
    localparam int TO  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          ena;
    logic          card_present;
    logic          sdata;
    logic          isCardAttached;
    logic [CB-1:0] code;
    logic [MB-1:0] currentBalance;
    logic          frame_valid;
    logic          frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_err    = 0;

    metro_card_reader #(
        .CODE_BITS  (CB),
        .MONEY_BITS (MB),
        .DEBOUNCE   (DEB),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ena            (ena),
        .card_present   (card_present),
        .sdata          (sdata),
        .isCardAttached (isCardAttached),
        .code           (code),
        .currentBalance (currentBalance),
        .frame_valid    (frame_valid),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // Pulses last one clk, so sampling on the falling edge counts each once
    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err)   n_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference checksum: XOR of the nibbles of the number {balance, code}
    function automatic logic [3:0] model_csum(input int unsigned c, input int unsigned b);
        int unsigned v;
        logic [3:0]  s;
        v = (b << CB) | c;
        s = 4'd0;
        while (v != 0) begin
            s = s ^ 4'(v & 32'hF);
            v = v >> 4;
        end
        return s;
    endfunction

    // One ena tick carrying bit b (sdata settles through the synchroniser first)
    task automatic tick(input logic b);
        @(negedge clk);
        sdata = b;
        @(negedge clk);
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic insert_card();
        @(negedge clk);
        card_present = 1'b1;
        sdata        = 1'b1;
        repeat (3) @(negedge clk);
        repeat (DEB) tick(1'b1);
    endtask

    // Leaves the bench 3 clks after the raw contact falls
    task automatic remove_card();
        @(negedge clk);
        card_present = 1'b0;
        sdata        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [CB-1:0] c, input logic [MB-1:0] b,
                              input logic [3:0] s, input logic stop);
        tick(1'b0);
        for (int i = 0; i < CB; i++) tick(c[i]);
        for (int i = 0; i < MB; i++) tick(b[i]);
        for (int i = 0; i < 4; i++)  tick(s[i]);
        tick(stop);
    endtask

    // Send a frame and compare the reader's response with the model
    task automatic frame_and_check(input string tag, input logic [CB-1:0] c,
                                   input logic [MB-1:0] b, input int mode);
        logic [3:0] s;
        logic       stop;
        logic       good;
        int         v0, e0;
        s    = model_csum(c, b);
        stop = 1'b1;
        if (mode == 1) s = s ^ 4'($urandom_range(15, 1));
        if (mode == 2) stop = 1'b0;
        good = (mode == 0);
        v0 = n_valid;
        e0 = n_err;
        send_frame(c, b, s, stop);
        @(posedge clk);
        #1;
        check({tag, " valid_pulse"}, frame_valid, good);
        check({tag, " err_pulse"}, frame_err, !good);
        check({tag, " attached"}, isCardAttached, good);
        check({tag, " code"}, code, good ? c : '0);
        check({tag, " balance"}, currentBalance, good ? b : '0);
        @(posedge clk);
        #1;
        check({tag, " valid_count"}, n_valid - v0, good ? 1 : 0);
        check({tag, " err_count"}, n_err - e0, good ? 0 : 1);
    endtask

    initial begin
        logic [CB-1:0] rc;
        logic [MB-1:0] rb;
        int            v0, e0, mode;

        reset        = 1'b0;
        ena          = 1'b0;
        card_present = 1'b0;
        sdata        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst attached", isCardAttached, 0);
        check("rst code", code, 0);
        check("rst balance", currentBalance, 0);
        check("rst valid", frame_valid, 0);
        check("rst err", frame_err, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst attached", isCardAttached, 0);

        // Known frame: code 42, balance 100, checksum 0
        insert_card();
        frame_and_check("known", 6'd42, 14'd100, 0);
        check("known csum_model", model_csum(42, 100), 0);
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(1, 0)));
        check("hold code", code, 42);
        check("hold balance", currentBalance, 100);
        check("hold attached", isCardAttached, 1);
        e0 = n_err;
        remove_card();
        check("removed attached", isCardAttached, 0);
        check("removed code", code, 0);
        check("removed balance", currentBalance, 0);
        check("removed err_count", n_err - e0, 0);

        // Bad checksum, then a good frame without removal is ignored
        insert_card();
        send_frame(6'd42, 14'd100, 4'h1, 1'b1);
        @(posedge clk);
        #1;
        check("badcsum err_pulse", frame_err, 1);
        check("badcsum attached", isCardAttached, 0);
        v0 = n_valid;
        send_frame(6'd42, 14'd100, 4'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("error_locked valid_count", n_valid - v0, 0);
        check("error_locked code", code, 0);
        remove_card();

        // Short insertion: three ticks only
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        card_present = 1'b1;
        repeat (3) @(negedge clk);
        repeat (DEB - 1) tick(1'b1);
        remove_card();
        repeat (TO + 2) tick(1'b1);
        check("short valid_count", n_valid - v0, 0);
        check("short err_count", n_err - e0, 0);

        // Start bit arriving on the last allowed tick
        insert_card();
        repeat (TO - 1) tick(1'b1);
        frame_and_check("late_start", 6'd7, 14'd9999, 0);
        remove_card();

        // No start bit at all
        insert_card();
        e0 = n_err;
        repeat (TO - 1) tick(1'b1);
        check("timeout early err_count", n_err - e0, 0);
        tick(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("timeout err_count", n_err - e0, 1);
        v0 = n_valid;
        send_frame(6'd1, 14'd2, model_csum(1, 2), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("timeout locked valid_count", n_valid - v0, 0);
        remove_card();

        // Removal part-way through the frame
        insert_card();
        v0 = n_valid;
        e0 = n_err;
        tick(1'b0);
        for (int i = 0; i < 9; i++) tick(1'($urandom_range(1, 0)));
        remove_card();
        check("abandon attached", isCardAttached, 0);
        check("abandon valid_count", n_valid - v0, 0);
        check("abandon err_count", n_err - e0, 0);
        insert_card();
        frame_and_check("after_abandon", 6'd63, 14'h3FFF, 0);

        // Asynchronous reset while holding a card
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_hold attached", isCardAttached, 0);
        check("rst_hold code", code, 0);
        check("rst_hold balance", currentBalance, 0);
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset mid-DATA
        insert_card();
        e0 = n_err;
        tick(1'b0);
        for (int i = 0; i < 10; i++) tick(1'($urandom_range(1, 0)));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_data attached", isCardAttached, 0);
        check("rst_data valid", frame_valid, 0);
        check("rst_data err", frame_err, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_data err_count", n_err - e0, 0);
        insert_card();
        frame_and_check("after_rst", 6'd21, 14'd5000, 0);
        remove_card();

        // Randomized frames
        for (int k = 0; k < 20; k++) begin
            rc   = CB'($urandom);
            rb   = MB'($urandom);
            mode = ($urandom_range(9, 0) < 6) ? 0 : int'($urandom_range(2, 1));
            insert_card();
            repeat ($urandom_range(TO - 1, 0)) tick(1'b1);
            frame_and_check($sformatf("rand%0d", k), rc, rb, mode);
            remove_card();
            check($sformatf("rand%0d cleared", k), {isCardAttached, code, currentBalance}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_metro_card_reader
`default_nettype wire

// File: doc/metro_card_reader.md
METRO_CARD_READER -- requirements
Module: metro_card_reader

Interface
REQ-001 SHALL have parameter CODE_BITS, default 6, width of the card code field.
REQ-002 SHALL have parameter MONEY_BITS, default 14, width of the card balance field.
REQ-003 SHALL have parameter DEBOUNCE, default 4, number of consecutive ena ticks card_present must stay high before acceptance.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum ena ticks from debounce completion to the start bit.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port ena, input, 1 bit, sample/tick enable; all counting and bit sampling occur only on clk edges with ena=1.
REQ-008 SHALL have port card_present, input, 1 bit, raw and unsynchronised card-presence contact.
REQ-009 SHALL have port sdata, input, 1 bit, serial card line; it idles high.
REQ-010 SHALL have port isCardAttached, output, 1 bit, high while a verified frame is held.
REQ-011 SHALL have port code, output, CODE_BITS, the verified card code.
REQ-012 SHALL have port currentBalance, output, MONEY_BITS, the verified card balance.
REQ-013 SHALL have port frame_valid, output, 1 bit, a one-clk pulse on checksum pass.
REQ-014 SHALL have port frame_err, output, 1 bit, a one-clk pulse on checksum, stop-bit or timeout failure.

Function
REQ-015 card_present and sdata SHALL each pass through a 2-flop synchroniser before use.
REQ-016 Frame format, LSB first: start bit 0, CODE_BITS code, MONEY_BITS balance, 4-bit checksum, stop bit 1 (26 bits at defaults).
REQ-017 Checksum SHALL be the XOR of all nibbles of {balance,code}, zero-padded at the MSB end to a multiple of 4 bits.
REQ-018 SHALL implement the states IDLE, DEBOUNCE, WAIT_START, DATA, CHECK, HOLD and ERROR.
REQ-019 IDLE: on synchronised card_present=1, go to DEBOUNCE and clear the debounce count.
REQ-020 DEBOUNCE: on each ena tick with card_present=1, increment the count; at count=DEBOUNCE, go to WAIT_START; card_present=0 on any tick returns the FSM to IDLE.
REQ-021 WAIT_START: an ena tick with sdata=0 goes to DATA with the bit index at 0; after TIMEOUT ticks without a start bit, go to ERROR.
REQ-022 DATA: shift one bit per ena tick into a shift register; after the stop-bit slot, go to CHECK.
REQ-023 CHECK lasts exactly one clk: if the checksum matches and stop=1, load code and currentBalance, pulse frame_valid and go to HOLD; otherwise pulse frame_err and go to ERROR.
REQ-024 HOLD: isCardAttached=1 and outputs stable; card_present=0, sampled without ena, goes to IDLE on the next clk.
REQ-025 ERROR: isCardAttached=0; the FSM stays in ERROR until card_present=0, then goes to IDLE, so re-reading requires card removal.
REQ-026 Card removal in any state SHALL go to IDLE within 1 clk of the synchronised input falling, abandoning any partial frame without a frame_err pulse.
REQ-027 code and currentBalance SHALL clear to 0 on entry to IDLE and SHALL change only in CHECK.
REQ-028 Latency: the frame_valid pulse occurs 1 clk after the ena tick that samples the stop bit; isCardAttached rises in the same clk as frame_valid.
REQ-029 Counters SHALL saturate and never wrap; the bit index width SHALL be ceil(log2(CODE_BITS+MONEY_BITS+6)).

Reset
REQ-030 On reset=0, the FSM SHALL go to IDLE asynchronously and all counters, synchronisers and shift registers SHALL clear, with synchroniser flops clearing to the idle level (sdata 1, card_present 0).
REQ-031 All outputs SHALL be 0 during and after reset until a valid frame is received.
REQ-032 Reset asserted mid-frame SHALL discard the frame without pulsing frame_err.

Structure
REQ-033 Package metro_pkg SHALL hold the reader state encoding, FRAME_BITS, and the CODE_BITS/MONEY_BITS defaults shared with the downstream fare FSM.
REQ-034 The block SHALL contain one sub-module, metro_debouncer (synchroniser plus DEBOUNCE counter), instantiated for card_present.

Verification
REQ-035 Card present for 4 ticks, frame with code=6'b101010, balance=14'd100, checksum=4'h0, stop=1 -> frame_valid pulse, isCardAttached=1, code=42, currentBalance=100.
REQ-036 Same frame with checksum=4'h1 -> frame_err pulse, isCardAttached=0, outputs 0, and no read until card_present is cycled.
REQ-037 card_present high for 3 ticks then low -> FSM returns to IDLE and no frame pulses occur.
REQ-038 No start bit for 15 ticks after debounce -> frame_err pulse and ERROR state.
REQ-039 card_present dropped at bit 10 of the frame -> IDLE within 3 clks (2 synchroniser flops plus 1 clk) with no pulse; card_present dropped in HOLD -> isCardAttached=0 and code and currentBalance cleared.
REQ-040 reset=0 asserted mid-DATA -> all outputs 0 immediately, and the next full valid frame is accepted normally.
